// File: rtl/instr_sequencer_if.sv
// Instruction offer channel into the sequencer: valid/ready handshake plus opcode and register fields.
interface instr_sequencer_if;
   logic       ins_valid;
   logic       ins_ready;
   logic [2:0] ins_func;
   logic [2:0] ins_rx;
   logic [2:0] ins_ry;

   modport master (output ins_valid, ins_func, ins_rx, ins_ry, input ins_ready);
   modport slave  (input ins_valid, ins_func, ins_rx, ins_ry, output ins_ready);
endinterface

// File: rtl/instr_sequencer.sv
// Shared-bus datapath sequencer: buffers instructions in a small FIFO and issues them as
// timed control steps (register in/out enables, A/G loads, ALU select) one at a time.
module instr_sequencer #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   instr_sequencer_if.slave    ins,
   output logic [7:0]          r_in,
   output logic [7:0]          r_out,
   output logic                din_out,
   output logic                a_in,
   output logic                g_in,
   output logic                g_out,
   output logic                add_sub,
   output logic [1:0]          alu_sel,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_MOV  = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;

   typedef struct packed {
      logic [2:0] func;
      logic [2:0] rx;
      logic [2:0] ry;
   } instr_t;

   typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

   instr_t          mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   instr_t          ir;
   state_t          state;
   state_t          state_next;

   // Register Rn maps to bit 7-n of the enable vectors.
   function automatic logic [7:0] reg_sel(input logic [2:0] r);
      return 8'h80 >> r;
   endfunction

   // Ready depends only on registered occupancy, never on this cycle's pop.
   assign full          = (count == CW'(FIFO_DEPTH));
   assign empty         = (count == '0);
   assign ins.ins_ready = !full && !reset;
   assign push          = ins.ins_valid && ins.ins_ready;
   assign pop           = (state == IDLE) && run && !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{func: ins.ins_func, rx: ins.ins_rx, ry: ins.ins_ry};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ir    <= '0;
      end else begin
         state <= state_next;
         if (pop) ir <= mem[rd_ptr];
      end
   end

   // Next state and Moore control decode from state + instruction register.
   always_comb begin
      state_next = IDLE;
      r_in       = '0;
      r_out      = '0;
      din_out    = 1'b0;
      a_in       = 1'b0;
      g_in       = 1'b0;
      g_out      = 1'b0;
      add_sub    = 1'b0;
      alu_sel    = 2'b00;
      done       = 1'b0;
      err        = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: state_next = pop ? T1 : IDLE;
         T1: begin
            case (ir.func)
               OP_LOAD: begin
                  din_out = 1'b1;
                  r_in    = reg_sel(ir.rx);
                  done    = 1'b1;
               end
               OP_MOV: begin
                  r_out = reg_sel(ir.ry);
                  r_in  = reg_sel(ir.rx);
                  done  = 1'b1;
               end
               OP_ADD, OP_SUB, OP_XOR: begin
                  r_out      = reg_sel(ir.rx);
                  a_in       = 1'b1;
                  state_next = T2;
               end
               default: begin
                  done = 1'b1;
                  err  = 1'b1;
               end
            endcase
         end
         T2: begin
            r_out      = reg_sel(ir.ry);
            g_in       = 1'b1;
            state_next = T3;
            case (ir.func)
               OP_ADD:  alu_sel = 2'b01;
               OP_SUB: begin
                  alu_sel = 2'b10;
                  add_sub = 1'b1;
               end
               default: alu_sel = 2'b00;
            endcase
         end
         T3: begin
            g_out = 1'b1;
            r_in  = reg_sel(ir.rx);
            done  = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of instructions with hand-derived control steps,
// hand-written timing sequences, and a random stream, all checked through an expected-step queue.
module tb_instr_sequencer;

   typedef struct packed {
      logic [7:0] r_in;
      logic [7:0] r_out;
      logic       din_out;
      logic       a_in;
      logic       g_in;
      logic       g_out;
      logic       add_sub;
      logic [1:0] alu_sel;
      logic       done;
      logic       err;
   } ctl_t;

   typedef struct {
      logic [2:0] f;
      logic [2:0] rx;
      logic [2:0] ry;
      int         n;
      ctl_t       s0;
      ctl_t       s1;
      ctl_t       s2;
   } vec_t;

   localparam ctl_t Z = '0;
   localparam int   NVEC = 12;

   logic       clk;
   logic       reset;
   logic       run;
   logic [7:0] r_in;
   logic [7:0] r_out;
   logic       din_out;
   logic       a_in;
   logic       g_in;
   logic       g_out;
   logic       add_sub;
   logic [1:0] alu_sel;
   logic       busy;
   logic       done;
   logic       err;

   instr_sequencer_if ins_if ();

   instr_sequencer #(.FIFO_DEPTH(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .ins     (ins_if.slave),
      .r_in    (r_in),
      .r_out   (r_out),
      .din_out (din_out),
      .a_in    (a_in),
      .g_in    (g_in),
      .g_out   (g_out),
      .add_sub (add_sub),
      .alu_sel (alu_sel),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   int    tests;
   int    fails;
   ctl_t  exp_q[$];
   ctl_t  cur_exp[3];
   int    cur_n;
   bit    chk_en;
   bit    accepted;
   bit    prev_done;
   bit    rnd_run;
   int    acc_cnt;
   int    done_cnt;
   vec_t  tbl[NVEC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   function automatic ctl_t mk(input int ri, input int ro, input int din, input int a, input int gi,
                               input int go, input int as, input int sel, input int d, input int e);
      return {8'(ri), 8'(ro), 1'(din), 1'(a), 1'(gi), 1'(go), 1'(as), 2'(sel), 1'(d), 1'(e)};
   endfunction

   function automatic ctl_t sample();
      return {r_in, r_out, din_out, a_in, g_in, g_out, add_sub, alu_sel, done, err};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour for one instruction, used for the random stream.
   task automatic set_model(input logic [2:0] f, input logic [2:0] rx, input logic [2:0] ry);
      logic [7:0] ox;
      logic [7:0] oy;
      ox = 8'd1 << (7 - int'(rx));
      oy = 8'd1 << (7 - int'(ry));
      cur_exp[0] = '0;
      cur_exp[1] = '0;
      cur_exp[2] = '0;
      case (f)
         3'd0: begin
            cur_n = 1;
            cur_exp[0].din_out = 1'b1; cur_exp[0].r_in = ox; cur_exp[0].done = 1'b1;
         end
         3'd1: begin
            cur_n = 1;
            cur_exp[0].r_out = oy; cur_exp[0].r_in = ox; cur_exp[0].done = 1'b1;
         end
         3'd2, 3'd3, 3'd4: begin
            cur_n = 3;
            cur_exp[0].r_out = ox; cur_exp[0].a_in = 1'b1;
            cur_exp[1].r_out = oy; cur_exp[1].g_in = 1'b1;
            cur_exp[1].alu_sel = (f == 3'd2) ? 2'b01 : (f == 3'd3) ? 2'b10 : 2'b00;
            cur_exp[1].add_sub = (f == 3'd3);
            cur_exp[2].g_out = 1'b1; cur_exp[2].r_in = ox; cur_exp[2].done = 1'b1;
         end
         default: begin
            cur_n = 1;
            cur_exp[0].done = 1'b1; cur_exp[0].err = 1'b1;
         end
      endcase
   endtask

   // One clock: check this cycle's outputs at the falling edge, record accepts, step past the rising edge.
   task automatic tick();
      ctl_t cur;
      ctl_t e;
      bit   ok;
      @(negedge clk);
      if (chk_en) begin
         cur = sample();
         ok  = ($countones(cur.r_out) + int'(cur.din_out) + int'(cur.g_out) <= 1) &&
               ($countones(cur.r_in) <= 1);
         check("bus_drivers", 32'(ok), 32'd1);
         if (busy) begin
            if (exp_q.size() == 0) check("unexpected_busy", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               check("step_ctl", 32'(cur), 32'(e));
            end
         end else begin
            check("idle_ctl", 32'(cur), 32'd0);
         end
         if (prev_done) check("bubble_after_done", 32'(busy), 32'd0);
         prev_done = cur.done;
         if (cur.done === 1'b1) done_cnt++;
         if (reset) begin
            check("ready_in_reset", 32'(ins_if.ins_ready), 32'd0);
            exp_q.delete();
            prev_done = 1'b0;
         end
      end
      accepted = ins_if.ins_valid && ins_if.ins_ready;
      if (accepted) begin
         for (int i = 0; i < cur_n; i++) exp_q.push_back(cur_exp[i]);
         acc_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [2:0] f, input logic [2:0] rx, input logic [2:0] ry, input int max_wait);
      int c;
      c = 0;
      ins_if.ins_func  = f;
      ins_if.ins_rx    = rx;
      ins_if.ins_ry    = ry;
      ins_if.ins_valid = 1'b1;
      accepted = 1'b0;
      while (!accepted && c < max_wait) begin
         if (rnd_run) run = ($urandom_range(0, 3) != 0);
         tick();
         c++;
      end
      ins_if.ins_valid = 1'b0;
      check("accept_in_budget", 32'(accepted), 32'd1);
   endtask

   task automatic load_vec(input vec_t v);
      cur_exp[0] = v.s0;
      cur_exp[1] = v.s1;
      cur_exp[2] = v.s2;
      cur_n      = v.n;
   endtask

   task automatic drain(input int max_wait);
      int c;
      c = 0;
      run = 1'b1;
      while ((exp_q.size() != 0 || busy) && c < max_wait) begin
         tick();
         c++;
      end
      check("drain_in_budget", 32'(exp_q.size() == 0 && busy == 1'b0), 32'd1);
   endtask

   initial begin
      int pat[9];
      int acc_at;
      int acc0;
      int done0;
      logic [2:0] f;
      logic [2:0] rx;
      logic [2:0] ry;

      tests = 0; fails = 0; cur_n = 0; chk_en = 1'b0; accepted = 1'b0; prev_done = 1'b0;
      rnd_run = 1'b0; acc_cnt = 0; done_cnt = 0;
      reset = 1'b1; run = 1'b0;
      ins_if.ins_valid = 1'b0; ins_if.ins_func = '0; ins_if.ins_rx = '0; ins_if.ins_ry = '0;

      tbl[0]  = '{3'd0, 3'd2, 3'd0, 1, mk('h20, 0, 1, 0, 0, 0, 0, 0, 1, 0), Z, Z};
      tbl[1]  = '{3'd2, 3'd1, 3'd5, 3, mk(0, 'h40, 0, 1, 0, 0, 0, 0, 0, 0),
                  mk(0, 'h04, 0, 0, 1, 0, 0, 1, 0, 0), mk('h40, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
      tbl[2]  = '{3'd3, 3'd1, 3'd5, 3, mk(0, 'h40, 0, 1, 0, 0, 0, 0, 0, 0),
                  mk(0, 'h04, 0, 0, 1, 0, 1, 2, 0, 0), mk('h40, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
      tbl[3]  = '{3'd4, 3'd1, 3'd5, 3, mk(0, 'h40, 0, 1, 0, 0, 0, 0, 0, 0),
                  mk(0, 'h04, 0, 0, 1, 0, 0, 0, 0, 0), mk('h40, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
      tbl[4]  = '{3'd1, 3'd3, 3'd3, 1, mk('h10, 'h10, 0, 0, 0, 0, 0, 0, 1, 0), Z, Z};
      tbl[5]  = '{3'd2, 3'd3, 3'd3, 3, mk(0, 'h10, 0, 1, 0, 0, 0, 0, 0, 0),
                  mk(0, 'h10, 0, 0, 1, 0, 0, 1, 0, 0), mk('h10, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
      tbl[6]  = '{3'd7, 3'd4, 3'd6, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), Z, Z};
      tbl[7]  = '{3'd1, 3'd0, 3'd7, 1, mk('h80, 'h01, 0, 0, 0, 0, 0, 0, 1, 0), Z, Z};
      tbl[8]  = '{3'd0, 3'd7, 3'd2, 1, mk('h01, 0, 1, 0, 0, 0, 0, 0, 1, 0), Z, Z};
      tbl[9]  = '{3'd5, 3'd1, 3'd1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), Z, Z};
      tbl[10] = '{3'd3, 3'd0, 3'd7, 3, mk(0, 'h80, 0, 1, 0, 0, 0, 0, 0, 0),
                  mk(0, 'h01, 0, 0, 1, 0, 1, 2, 0, 0), mk('h80, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
      tbl[11] = '{3'd6, 3'd0, 3'd0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), Z, Z};

      // Reset state
      repeat (3) tick();
      check("ready_during_reset", 32'(ins_if.ins_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("reset_ctl", 32'(sample()), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("ready_after_reset", 32'(ins_if.ins_ready), 32'd1);
      chk_en = 1'b1;
      run = 1'b1;

      // LOAD R2 accepted at cycle k: T1 at k+2, idle at k+3
      load_vec(tbl[0]);
      offer(tbl[0].f, tbl[0].rx, tbl[0].ry, 10);
      tick();
      check("load_din_out", 32'(din_out), 32'd1);
      check("load_r_in", 32'(r_in), 32'h20);
      check("load_done", 32'(done), 32'd1);
      check("load_busy", 32'(busy), 32'd1);
      tick();
      check("load_busy_after", 32'(busy), 32'd0);

      // Instruction table, back to back
      for (int i = 0; i < NVEC; i++) begin
         load_vec(tbl[i]);
         offer(tbl[i].f, tbl[i].rx, tbl[i].ry, 20);
      end
      drain(100);

      // Backpressure with run held low, then release
      run = 1'b0;
      set_model(3'd0, 3'd6, 3'd0);
      offer(3'd0, 3'd6, 3'd0, 10);
      set_model(3'd2, 3'd2, 3'd4);
      offer(3'd2, 3'd2, 3'd4, 10);
      check("ready_when_full", 32'(ins_if.ins_ready), 32'd0);
      set_model(3'd1, 3'd1, 3'd7);
      ins_if.ins_func = 3'd1; ins_if.ins_rx = 3'd1; ins_if.ins_ry = 3'd7;
      ins_if.ins_valid = 1'b1;
      repeat (4) begin
         check("ready_held", 32'(ins_if.ins_ready), 32'd0);
         tick();
         check("held_not_accepted", 32'(accepted), 32'd0);
      end
      run = 1'b1;
      pat = '{0, 1, 0, 1, 1, 1, 0, 1, 0};
      acc_at = -1;
      for (int i = 0; i < 9; i++) begin
         check("release_busy_pattern", 32'(busy), 32'(pat[i]));
         if (i == 0) check("ready_no_pop_path", 32'(ins_if.ins_ready), 32'd0);
         tick();
         if (accepted) begin
            acc_at = i;
            ins_if.ins_valid = 1'b0;
         end
      end
      check("third_accept_cycle", 32'(acc_at), 32'd1);
      drain(50);

      // Reset during T2 of XOR with a LOAD queued behind it
      set_model(3'd4, 3'd2, 3'd6);
      offer(3'd4, 3'd2, 3'd6, 10);
      set_model(3'd0, 3'd5, 3'd0);
      offer(3'd0, 3'd5, 3'd0, 10);
      check("xor_t1_a_in", 32'(a_in), 32'd1);
      tick();
      check("xor_t2_g_in", 32'(g_in), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("abort_ctl", 32'(sample()), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(ins_if.ins_ready), 32'd1);
      repeat (4) begin
         tick();
         check("discarded_stays_idle", 32'(busy), 32'd0);
      end

      // Random stream with random gaps and run
      acc0 = acc_cnt;
      done0 = done_cnt;
      rnd_run = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         f  = 3'($urandom_range(0, 7));
         rx = 3'($urandom_range(0, 7));
         ry = 3'($urandom_range(0, 7));
         set_model(f, rx, ry);
         repeat ($urandom_range(0, 2)) begin
            run = ($urandom_range(0, 3) != 0);
            tick();
         end
         offer(f, rx, ry, 200);
      end
      rnd_run = 1'b0;
      drain(200);
      check("done_vs_accepted", 32'(done_cnt - done0), 32'(acc_cnt - acc0));
      check("accepted_total", 32'(acc_cnt - acc0), 32'd2000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
